// File: rtl/profiler_window_controller_if.sv
// ---------------------------------------------------------------------------
// profiler_window_controller_if
//
// Purpose: valid/ready word stream carrying one profiler snapshot per window
// from the window controller to the host-side readout logic.
//
// Signals:
//   out_valid  - word on out_data/out_index/out_last is valid
//   out_ready  - readout side accepts the word this cycle
//   out_data   - stream word (DATA_W bits)
//   out_index  - beat index within the window
//   out_last   - final beat of the window
//
// Modports:
//   master - the window controller (drives the word, samples ready)
//   slave  - the readout logic (samples the word, drives ready)
// ---------------------------------------------------------------------------
interface profiler_window_controller_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/profiler_window_controller.sv
// ---------------------------------------------------------------------------
// profiler_window_controller
//
// Purpose: runs the instruction profiler through fixed-length sampling
// windows. Enables the profiler for W cycles (or until stop), snapshots all
// counters, clears the profiler, then streams the snapshot out word by word.
// Single-shot or continuous (auto re-arm after each drain).
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - pulse, begins a window from IDLE
//   stop           - pulse, ends the current window early / ends continuous
//   continuous     - sampled at start, re-arm automatically after drain
//   window_cycles  - window length in cycles, sampled at start (0 acts as 1)
//   counter_vec    - profiler counters, word i at bits [i*DATA_W +: DATA_W]
//   prof_enable    - profiler enable; low clears the profiler
//   stream         - snapshot word stream (master side of the interface)
//   window_id      - number of completed windows, wraps at 2^ID_W
//   busy           - controller is not idle
//   saturated      - sticky, some captured word was all-ones
//
// Build option:
//   PROF_HEADER_EN - when defined, each drain starts with a header beat
//                    {16'hAB5C, window_id[15:0]} at index 0 and the counters
//                    move to indices 1..NUM_COUNTERS.
// ---------------------------------------------------------------------------
module profiler_window_controller #(
    parameter int NUM_COUNTERS = 10,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           continuous,
    input  logic [31:0]                    window_cycles,
    input  logic [NUM_COUNTERS*DATA_W-1:0] counter_vec,
    output logic                           prof_enable,
    profiler_window_controller_if.master   stream,
    output logic [ID_W-1:0]                window_id,
    output logic                           busy,
    output logic                           saturated
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SNAP,
        CLEAR,
        DRAIN
    } state_t;

`ifdef PROF_HEADER_EN
    localparam int HDR_BEATS = 1;
`else
    localparam int HDR_BEATS = 0;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NUM_COUNTERS - 1 + HDR_BEATS);

    state_t                               state;
    state_t                               state_next;
    logic [31:0]                          run_cnt;
    logic [31:0]                          win_len;
    logic                                 cont_lat;
    logic [NUM_COUNTERS-1:0][DATA_W-1:0]  snap;
    logic [3:0]                           beat_idx;
    logic [3:0]                           ctr_sel;
    logic [DATA_W-1:0]                    word_sel;
    logic                                 beat_fire;
    logic                                 beat_final;
    logic                                 any_ones;

    // A beat leaves only while draining and the reader is ready; the final
    // beat is the one that closes the window.
    assign beat_fire  = (state == DRAIN) && stream.out_ready;
    assign beat_final = beat_fire && (beat_idx == LAST_IDX);

    // Flags an all-ones counter word; only looked at on the snapshot edge.
    always_comb begin
        any_ones = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (counter_vec[i*DATA_W +: DATA_W] == {DATA_W{1'b1}}) begin
                any_ones = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RUN ends either at the last window cycle or on the
    // cycle after stop is seen. A stop that coincides with the final beat
    // still cancels the re-arm, even though the latched bit clears a cycle
    // later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop || (run_cnt == win_len - 32'd1)) begin
                    state_next = SNAP;
                end
            end
            SNAP: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                state_next = DRAIN;
            end
            DRAIN: begin
                if (beat_final) begin
                    state_next = (cont_lat && !stop) ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window bookkeeping: latched length and mode, cycle counter, snapshot
    // capture, beat pointer, completed-window count and the sticky
    // saturation flag. The snapshot is taken at the closing edge of SNAP,
    // which is also the edge on which the profiler would count the SNAP
    // cycle, so only RUN-cycle activity lands in the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt   <= 32'd0;
            win_len   <= 32'd1;
            cont_lat  <= 1'b0;
            snap      <= '0;
            beat_idx  <= 4'd0;
            window_id <= '0;
            saturated <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_len  <= (window_cycles == 32'd0) ? 32'd1 : window_cycles;
                        cont_lat <= continuous;
                        run_cnt  <= 32'd0;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    if (stop) begin
                        cont_lat <= 1'b0;
                    end
                end
                SNAP: begin
                    snap <= counter_vec;
                    if (any_ones) begin
                        saturated <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        cont_lat <= 1'b0;
                    end
                    if (beat_final) begin
                        beat_idx  <= 4'd0;
                        window_id <= window_id + ID_W'(1);
                        run_cnt   <= 32'd0;
                    end else if (beat_fire) begin
                        beat_idx <= beat_idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the current state. The profiler is enabled in
    // RUN and SNAP and held cleared everywhere else, including a stalled
    // drain.
    always_comb begin
        ctr_sel  = beat_idx - 4'(HDR_BEATS);
        word_sel = snap[ctr_sel];
`ifdef PROF_HEADER_EN
        if (beat_idx == 4'd0) begin
            word_sel = DATA_W'({16'hAB5C, 16'(window_id)});
        end
`endif
        prof_enable      = (state == RUN) || (state == SNAP);
        busy             = (state != IDLE);
        stream.out_valid = (state == DRAIN);
        stream.out_index = (state == DRAIN) ? beat_idx : 4'd0;
        stream.out_last  = (state == DRAIN) && (beat_idx == LAST_IDX);
        stream.out_data  = (state == DRAIN) ? word_sel : '0;
    end

endmodule

// File: tb/tb_profiler_window_controller.sv
// ---------------------------------------------------------------------------
// tb_profiler_window_controller
//
// Bench for profiler_window_controller. A behavioural profiler model feeds
// counter_vec; every window started pushes its expected beats into a
// scoreboard queue and a stream monitor pops and compares each accepted
// beat. Honours PROF_HEADER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_profiler_window_controller;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 16;

`ifdef PROF_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  index;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              continuous;
    logic [31:0]       window_cycles;
    logic [NC*DW-1:0]  counter_vec;
    logic              prof_enable;
    logic [IW-1:0]     window_id;
    logic              busy;
    logic              saturated;

    profiler_window_controller_if #(.DATA_W(DW)) stream_bus ();

    profiler_window_controller #(
        .NUM_COUNTERS(NC),
        .DATA_W(DW),
        .ID_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .continuous(continuous),
        .window_cycles(window_cycles),
        .counter_vec(counter_vec),
        .prof_enable(prof_enable),
        .stream(stream_bus),
        .window_id(window_id),
        .busy(busy),
        .saturated(saturated)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    exp_wid = 0;
    beat_t sb[$];

    // Profiler model: each counter adds its per-cycle increment while
    // enabled and is zeroed whenever enable is low.
    logic [31:0] prof_cnt [NC];
    int          inc [NC];
    bit          sat_force = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            prof_cnt[i] <= prof_enable ? prof_cnt[i] + 32'(inc[i]) : 32'd0;
        end
    end

    always_comb begin
        counter_vec = '0;
        for (int i = 0; i < NC; i++) begin
            counter_vec[i*DW +: DW] = (sat_force && i == NC - 1) ? 32'hFFFF_FFFF : prof_cnt[i];
        end
    end

    // Stream monitor: compares each accepted beat against the scoreboard
    // and checks that a stalled word stays put until it is taken.
    bit          hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic [3:0]  hold_idx;
    beat_t       got;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && stream_bus.out_valid) begin
                checks++;
                if (stream_bus.out_data !== hold_data || stream_bus.out_index !== hold_idx) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got idx=%0d data=%h expected idx=%0d data=%h",
                             stream_bus.out_index, stream_bus.out_data, hold_idx, hold_data);
                end
            end
            if (stream_bus.out_valid && stream_bus.out_ready) begin
                hold_pending = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got idx=%0d data=%h expected no beat",
                             stream_bus.out_index, stream_bus.out_data);
                end else begin
                    got = sb.pop_front();
                    if (stream_bus.out_data !== got.data || stream_bus.out_index !== got.index ||
                        stream_bus.out_last !== got.last) begin
                        errors++;
                        $display("[TB] FAIL beat: got idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                                 stream_bus.out_index, stream_bus.out_data, stream_bus.out_last,
                                 got.index, got.data, got.last);
                    end
                end
            end else begin
                hold_pending = stream_bus.out_valid;
                hold_data    = stream_bus.out_data;
                hold_idx     = stream_bus.out_index;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int mult, input int add, input int modv);
        for (int i = 0; i < NC; i++) begin
            inc[i] = (i * mult + add) % modv;
        end
    endtask

    // Expected beats of one window given the number of RUN cycles.
    task automatic push_window(input int run_cycles);
        beat_t b;
        if (HDR == 1) begin
            b.data  = {16'hAB5C, 16'(exp_wid)};
            b.index = 4'd0;
            b.last  = 1'b0;
            sb.push_back(b);
        end
        for (int i = 0; i < NC; i++) begin
            b.data  = (sat_force && i == NC - 1) ? 32'hFFFF_FFFF : 32'(run_cycles * inc[i]);
            b.index = 4'(i + HDR);
            b.last  = (i == NC - 1);
            sb.push_back(b);
        end
        exp_wid = (exp_wid + 1) % (1 << IW);
    endtask

    task automatic start_window(input int w, input bit cont);
        window_cycles = 32'(w);
        continuous    = cont;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_beat(input int idx, input int wid, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (stream_bus.out_valid && stream_bus.out_index == 4'(idx) && window_id == IW'(wid)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        window_cycles = 32'd0;
        stream_bus.out_ready = 1'b1;
        for (int i = 0; i < NC; i++) inc[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({prof_enable, stream_bus.out_valid, stream_bus.out_last, busy, saturated} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got en=%b v=%b last=%b busy=%b sat=%b expected all 0",
                     prof_enable, stream_bus.out_valid, stream_bus.out_last, busy, saturated);
        end
        checks++;
        if (stream_bus.out_data !== 32'd0 || stream_bus.out_index !== 4'd0 || window_id !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got data=%h idx=%0d wid=%0d expected 0 0 0",
                     stream_bus.out_data, stream_bus.out_index, window_id);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_window();
        bit en_tr [11];
        bit v_tr [11];
        int en_hi;
        bit ok;
        for (int i = 0; i < NC; i++) inc[i] = (i == 0) ? 1 : 0;
        push_window(8);
        start_window(8, 1'b0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            en_tr[k] = prof_enable;
            v_tr[k]  = stream_bus.out_valid;
        end
        en_hi = 0;
        for (int k = 0; k < 9; k++) en_hi += int'(en_tr[k]);
        checks++;
        if (en_hi != 9) begin
            errors++;
            $display("[TB] FAIL single_enable_cycles: got %0d expected 9", en_hi);
        end
        checks++;
        if (en_tr[9] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_clear_cycle: got en=%b expected 0", en_tr[9]);
        end
        checks++;
        if (v_tr[9] !== 1'b0 || v_tr[10] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_first_valid: got v9=%b v10=%b expected 0 1", v_tr[9], v_tr[10]);
        end
        wait_idle(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_drain_timeout: got busy=%b left=%0d expected idle", busy, sb.size());
        end
        checks++;
        if (window_id !== IW'(exp_wid)) begin
            errors++;
            $display("[TB] FAIL single_window_id: got %0d expected %0d", window_id, exp_wid);
        end
    endtask

    task automatic test_w_zero();
        bit en_tr [4];
        bit v_tr [4];
        bit ok;
        set_inc(1, 1, 11);
        push_window(1);
        start_window(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            en_tr[k] = prof_enable;
            v_tr[k]  = stream_bus.out_valid;
        end
        checks++;
        if ({en_tr[0], en_tr[1], en_tr[2]} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL wzero_enable: got %b%b%b expected 110", en_tr[0], en_tr[1], en_tr[2]);
        end
        checks++;
        if (v_tr[2] !== 1'b0 || v_tr[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wzero_first_valid: got v2=%b v3=%b expected 0 1", v_tr[2], v_tr[3]);
        end
        wait_idle(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wzero_drain_timeout: got busy=%b left=%0d expected idle", busy, sb.size());
        end
    endtask

    task automatic test_stop_early();
        bit ok;
        set_inc(3, 1, 7);
        push_window(21);
        start_window(100, 1'b1);
        repeat (20) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (prof_enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_snap: got en=%b busy=%b expected 1 1", prof_enable, busy);
        end
        @(negedge clk);
        checks++;
        if (prof_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_clear: got en=%b expected 0", prof_enable);
        end
        wait_idle(60, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_drain_timeout: got busy=%b left=%0d expected idle", busy, sb.size());
        end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || prof_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_no_rearm: got busy=%b en=%b expected 0 0", busy, prof_enable);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_inc(5, 2, 9);
        stream_bus.out_ready = 1'b0;
        push_window(6);
        start_window(6, 1'b0);
        wait_beat(0, exp_wid - 1, 40, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_first_valid: got v=%b expected 1", stream_bus.out_valid);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (prof_enable !== 1'b0 || stream_bus.out_valid !== 1'b1 || stream_bus.out_index !== 4'd0) begin
            errors++;
            $display("[TB] FAIL stall_park: got en=%b v=%b idx=%0d expected 0 1 0",
                     prof_enable, stream_bus.out_valid, stream_bus.out_index);
        end
        checks++;
        if (sb.size() == 0 || stream_bus.out_data !== sb[0].data) begin
            errors++;
            $display("[TB] FAIL stall_park_data: got %h expected first queued beat", stream_bus.out_data);
        end
        tick();
        for (int c = 0; c < 200 && (busy || sb.size() != 0); c++) begin
            stream_bus.out_ready = pat[c % 4];
            tick();
        end
        stream_bus.out_ready = 1'b1;
        wait_idle(10, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_drain_timeout: got busy=%b left=%0d expected idle", busy, sb.size());
        end
    endtask

    task automatic test_continuous();
        bit ok;
        int base;
        base = exp_wid;
        set_inc(1, 1, 4);
        stream_bus.out_ready = 1'b1;
        repeat (3) push_window(4);
        start_window(4, 1'b1);
        wait_beat(5, base + 2, 300, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cont_third_drain: got wid=%0d expected %0d", window_id, base + 2);
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(50, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cont_drain_timeout: got busy=%b left=%0d expected idle", busy, sb.size());
        end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || window_id !== IW'(exp_wid)) begin
            errors++;
            $display("[TB] FAIL cont_end: got busy=%b wid=%0d expected 0 %0d", busy, window_id, exp_wid);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        checks++;
        if (saturated !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_before: got %b expected 0", saturated);
        end
        for (int i = 0; i < NC; i++) inc[i] = 1;
        sat_force = 1'b1;
        push_window(3);
        start_window(3, 1'b0);
        wait_idle(40, ok);
        sat_force = 1'b0;
        checks++;
        if (ok !== 1'b1 || saturated !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_set: got ok=%b sat=%b expected 1 1", ok, saturated);
        end
        push_window(2);
        start_window(2, 1'b0);
        wait_idle(40, ok);
        checks++;
        if (ok !== 1'b1 || saturated !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_sticky: got ok=%b sat=%b expected 1 1", ok, saturated);
        end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        for (int i = 0; i < NC; i++) inc[i] = 2;
        push_window(3);
        start_window(3, 1'b1);
        wait_beat(5, exp_wid - 1, 40, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_reach_beat5: got idx=%0d expected 5", stream_bus.out_index);
        end
        tick();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({stream_bus.out_valid, prof_enable, busy, saturated} !== 4'b0 || window_id !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_in_drain: got v=%b en=%b busy=%b sat=%b wid=%0d expected all 0",
                     stream_bus.out_valid, prof_enable, busy, saturated, window_id);
        end
        tick();
        rst = 1'b0;
        exp_wid = 0;
        tick();
        set_inc(2, 3, 5);
        push_window(2);
        start_window(2, 1'b0);
        wait_idle(40, ok);
        checks++;
        if (ok !== 1'b1 || window_id !== 16'd1) begin
            errors++;
            $display("[TB] FAIL rst_after_window: got ok=%b wid=%0d expected 1 1", ok, window_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_w_zero();
        test_stop_early();
        test_stall();
        test_continuous();
        test_saturate();
        test_reset_in_drain();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/profiler_window_controller.md
Name: profiler_window_controller

Overview:
Sequences the instruction profiler through fixed-length sampling windows. Drives the profiler's enable, snapshots its 10 counters at window end, then clears it. Streams the snapshot out as a valid/ready word sequence to the host-side readout logic. Sits between the profiler counter bank and the readout interface; supports single-shot and continuous windowing.

Parameters:
NUM_COUNTERS, 10, number of 32-bit profiler counters captured per window
DATA_W, 32, counter and output word width
ID_W, 16, window sequence-number width

Ports:
clk  input  1  single clock
rst  input  1  asynchronous active-high reset
start  input  1  pulse; begin a window from IDLE
stop  input  1  pulse; end the current window early / end continuous mode
continuous  input  1  sampled at start; 1 = re-arm automatically after drain
window_cycles  input  32  window length in cycles, sampled at start; 0 treated as 1
counter_vec  input  NUM_COUNTERS*DATA_W  profiler counters, word i at bits [i*32+:32], order load..atomic
prof_enable  output  1  drives profiler enable; low clears the profiler
out_valid  output  1  stream word valid
out_ready  input  1  stream word accepted when out_valid & out_ready
out_data  output  DATA_W  stream word
out_index  output  4  beat index within the window
out_last  output  1  final beat of the window
window_id  output  ID_W  count of completed windows, wraps at 2^ID_W
busy  output  1  state != IDLE
saturated  output  1  sticky; any captured word == 32'hFFFFFFFF

Behaviour:
- Reset (async, any state): state=IDLE, prof_enable=0, out_valid=0, out_data=0, out_index=0, out_last=0, window_id=0, busy=0, saturated=0, snapshot regs=0, cycle counter=0.
- States: IDLE, RUN, SNAP, CLEAR, DRAIN.
- IDLE: prof_enable=0. start -> RUN; latch window_cycles (0->1) and continuous; cycle counter=0. stop in IDLE ignored. If start and stop are coincident, start wins.
- RUN: prof_enable=1; cycle counter increments each cycle. RUN -> SNAP after exactly W cycles (counter==W-1), or on the cycle after stop is seen. stop also clears the latched continuous bit. start is ignored.
- SNAP: one cycle, prof_enable=1; at its closing edge all NUM_COUNTERS words of counter_vec are captured. Captured values reflect instructions issued during the RUN cycles only. saturated is set if any word is all-ones.
- CLEAR: one cycle, prof_enable=0; the profiler zeroes. Instructions issued in the SNAP and CLEAR cycles are intentionally discarded (2-cycle blind gap per window). Next state is DRAIN.
- DRAIN: out_valid=1 from the first DRAIN cycle.
  - Beats go out in index order 0..NUM_COUNTERS-1; out_data=snapshot[out_index].
  - Advance only on out_valid & out_ready. out_data and out_index are held stable while stalled.
  - out_last=1 on the final beat. On its acceptance: window_id+=1, out_valid=0.
  - Then -> RUN if the latched continuous bit is set (cycle counter=0, same W), else -> IDLE.
  - stop during DRAIN clears continuous; the drain always completes.
- Latency: start seen at edge t gives prof_enable=1 in cycle t+1. The first beat is valid W+2 cycles after RUN entry.
- window_id wraps from 2^ID_W-1 to 0. saturated is cleared only by rst.
- out_ready held low indefinitely: stall in DRAIN, no data lost, profiler stays cleared (prof_enable=0).

Optional Feature:
PROF_HEADER_EN defined:
- Each drain is prefixed by a header beat at out_index=0, out_data={16'hAB5C, window_id[15:0]}.
- Counters follow at indices 1..NUM_COUNTERS; out_last is on index NUM_COUNTERS.
Not defined: no header; counters occupy indices 0..NUM_COUNTERS-1.

Test Plan:
- W=8, continuous=0, 1 load issued per cycle in RUN: prof_enable high for 9 cycles (8 RUN + SNAP), then 1 low (CLEAR). Beat 0=8, beats 1..9=0. out_last on index 9; window_id 0->1; back to IDLE.
- W=0: behaves as W=1; exactly one RUN cycle precedes SNAP.
- W=100, stop at RUN cycle 20: SNAP follows next cycle. Counters reflect ~21 cycles of activity; end state IDLE even with continuous=1.
- out_ready toggled 1,0,0,1 during drain: out_index/out_data hold while stalled. All 10 beats appear in order, each exactly once.
- continuous=1, W=4, 3 windows, then stop mid-drain: window_id reaches 3, third drain completes, IDLE after.
- Assert rst during DRAIN at beat 5: next cycle out_valid=0, prof_enable=0, window_id=0, state IDLE. With PROF_HEADER_EN: first beat=32'hAB5C0000.
